// File: rtl/mul_unit_ctrl.sv
// ============================================================================
// Module      : mul_unit_ctrl
// Description : RV64M multiply control around an unsigned 64x64->128 multiplier
//               (operand sign handling, start pulse, result fix-up and select).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_unit_ctrl #(
    parameter int START_HOLD = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic         word,
    input  logic [63:0]  rs1,
    input  logic [63:0]  rs2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  result,
    output logic         mul_start,
    output logic [63:0]  mul_a,
    output logic [63:0]  mul_b,
    input  logic [127:0] mul_s,
    input  logic         mul_done
);

    localparam int c_CW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(START_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [c_CW-1:0] r_cnt;
    logic            r_wait2;
    logic [63:0]     r_mul_a;
    logic [63:0]     r_mul_b;
    logic            r_neg;
    logic [1:0]      r_op;
    logic            r_word;
    logic [63:0]     r_result;

    logic [63:0]     w_abs1;
    logic [63:0]     w_abs2;
    logic [63:0]     w_a;
    logic [63:0]     w_b;
    logic            w_neg;
    logic [127:0]    w_p;
    logic [63:0]     w_sel;
    logic            w_accept;
    logic            w_done_ok;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    // The first WAIT cycle may still see done from the previous operation.
    assign w_done_ok = (r_state == S_WAIT) && r_wait2 && mul_done;

    // 2^63 maps onto itself, which is the right magnitude when read unsigned.
    assign w_abs1 = rs1[63] ? (~rs1 + 64'd1) : rs1;
    assign w_abs2 = rs2[63] ? (~rs2 + 64'd1) : rs2;

    always_comb begin
        w_a   = rs1;
        w_b   = rs2;
        w_neg = 1'b0;
        if (word) begin
            w_a = {32'd0, rs1[31:0]};
            w_b = {32'd0, rs2[31:0]};
        end else begin
            case (op)
                2'b01: begin
                    w_a   = w_abs1;
                    w_b   = w_abs2;
                    w_neg = rs1[63] ^ rs2[63];
                end
                2'b10: begin
                    w_a   = w_abs1;
                    w_neg = rs1[63];
                end
                default: ;
            endcase
        end
    end

    assign w_p = r_neg ? (~mul_s + 128'd1) : mul_s;

    always_comb begin
        w_sel = w_p[127:64];
        if (r_word) begin
            w_sel = {{32{w_p[31]}}, w_p[31:0]};
        end else if (r_op == 2'b00) begin
            w_sel = w_p[63:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)          w_next = S_START;
            S_START: if (r_cnt == c_LAST)   w_next = S_WAIT;
            S_WAIT:  if (w_done_ok)         w_next = S_HOLD;
            S_HOLD:  if (out_ready)         w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_wait2  <= 1'b0;
            r_mul_a  <= 64'd0;
            r_mul_b  <= 64'd0;
            r_neg    <= 1'b0;
            r_op     <= 2'b00;
            r_word   <= 1'b0;
            r_result <= 64'd0;
        end else begin
            if (w_accept) begin
                r_mul_a <= w_a;
                r_mul_b <= w_b;
                r_neg   <= w_neg;
                r_op    <= op;
                r_word  <= word;
                r_cnt   <= '0;
                r_wait2 <= 1'b0;
            end
            if (r_state == S_START) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_WAIT) begin
                r_wait2 <= 1'b1;
            end
            if (w_done_ok) begin
                r_result <= w_sel;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_HOLD);
    assign mul_start = (r_state == S_START);
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_unit_ctrl.sv
// ============================================================================
// Module      : tb_mul_unit_ctrl
// Description : Scoreboard bench for mul_unit_ctrl with a behavioural multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_unit_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic         word;
    logic [63:0]  rs1;
    logic [63:0]  rs2;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  result;
    logic         mul_start;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic [127:0] mul_s = '0;
    logic         mul_done = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mul_unit_ctrl #(.START_HOLD(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_s(mul_s), .mul_done(mul_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural result computed from two's-complement products.
    function automatic logic [63:0] ref_mul(input logic [1:0] f_op, input logic f_word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        logic [31:0]  lo;
        if (f_word) begin
            lo = a[31:0] * b[31:0];
            return {{32{lo[31]}}, lo};
        end
        ea = (f_op == 2'b01 || f_op == 2'b10) ? {{64{a[63]}}, a} : {64'd0, a};
        eb = (f_op == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ea * eb;
        return (f_op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    // Multiplier model: garbage done/s during start and the first wait cycle,
    // then the true product after a random latency.
    initial begin
        int ph = 0;
        int cnt = 0;
        logic [63:0] ma = '0;
        logic [63:0] mb = '0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                ma = mul_a;
                mb = mul_b;
                ph = 1;
                mul_done = 1'b1;
                mul_s = {$urandom, $urandom, $urandom, $urandom};
            end else if (ph == 1) begin
                ph = 2;
            end else if (ph == 2 || ph == 3) begin
                if (ph == 2) cnt = $urandom_range(0, 4);
                else         cnt--;
                ph = 3;
                mul_done = 1'b0;
                if (cnt == 0) begin
                    mul_s = {64'd0, ma} * {64'd0, mb};
                    mul_done = 1'b1;
                    ph = 0;
                end
            end
        end
    end

    // Monitor: pops expected results on each output handshake.
    initial begin
        int start_cnt = 0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_q.delete();
                start_cnt = 0;
            end else begin
                if (mul_start) start_cnt++;
                if (out_valid) begin
                    chk("in_ready_in_hold", {63'd0, in_ready}, 64'd0);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_output", 64'd1, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("result", result, e);
                        end
                        chk("start_cycles", 64'(start_cnt), 64'd2);
                        start_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] e, input int bp);
        int n;
        logic [63:0] held;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        word      = w;
        rs1       = a;
        rs2       = b;
        out_ready = (bp == 0);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 2'($urandom);
        word     = 1'($urandom);
        rs1      = {$urandom, $urandom};
        rs2      = {$urandom, $urandom};
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
            out_ready = 1'b1;
            return;
        end
        held = result;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_result_stable", result, held);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_no_start", {63'd0, mul_start}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_take", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic rand_op();
        logic [1:0]  o;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        o = 2'($urandom);
        w = ($urandom_range(0, 4) == 0);
        if (w) o = 2'b00;
        case ($urandom_range(0, 3))
            0: a = 64'h8000_0000_0000_0000;
            1: a = 64'hFFFF_FFFF_FFFF_FFFF;
            default: a = {$urandom, $urandom};
        endcase
        b = ($urandom_range(0, 3) == 0) ? 64'(int'($urandom_range(0, 7)) - 4) : {$urandom, $urandom};
        issue(o, w, a, b, ref_mul(o, w, a, b), $urandom_range(0, 3));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        op = 2'b00;
        word = 1'b0;
        rs1 = '0;
        rs2 = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_mul_start", {63'd0, mul_start}, 64'd0);
        chk("rst_mul_a", mul_a, 64'd0);
        chk("rst_mul_b", mul_b, 64'd0);
        rst = 1'b0;

        issue(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        issue(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
        issue(2'b01, 1'b0, '1, '1, 64'd0, 0);
        issue(2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        issue(2'b10, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        issue(2'b00, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        issue(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 5);

        // Reset while the multiply is outstanding.
        @(negedge clk);
        in_valid = 1'b1;
        op = 2'b00;
        word = 1'b0;
        rs1 = 64'd5;
        rs2 = 64'd6;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (mul_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wait_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("wait_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("wait_rst_result", result, 64'd0);
        issue(2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 0);

        for (int i = 0; i < 200; i++) rand_op();

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
